// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers.
// 32-cycle shift-add multiply and restoring divide on operand magnitudes,
// with sign correction applied when the result is written into HI/LO.
module mips_cpu_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  CtrlALUOp,
    input  logic        CtrlHiSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_MULU = 5'd22;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_DIVU = 5'd23;
    localparam logic [4:0] OP_PAS  = 5'd19;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state, state_next;
    logic [5:0]  count;
    logic        is_div;
    logic        neg_q;      // quotient / full product must be negated
    logic        neg_r;      // remainder must be negated (dividend sign)
    logic        div_zero;
    logic [31:0] opnd;       // multiplicand or divisor magnitude
    logic [63:0] work;       // {upper partial, lower multiplier/quotient}

    logic        op_valid, op_signed, op_div, accept;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    logic [63:0] prod_fix;

    function automatic logic [31:0] neg_if32(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg_if64(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

    assign op_div    = (CtrlALUOp == OP_DIV) || (CtrlALUOp == OP_DIVU);
    assign op_signed = (CtrlALUOp == OP_MUL) || (CtrlALUOp == OP_DIV);
    assign op_valid  = op_div || (CtrlALUOp == OP_MUL) || (CtrlALUOp == OP_MULU);
    assign accept    = start && (state == IDLE) && op_valid;

    assign a_neg = op_signed && A[31];
    assign b_neg = op_signed && B[31];
    assign abs_a = neg_if32(a_neg, A);
    assign abs_b = neg_if32(b_neg, B);

    // One shift-add step: add multiplicand when multiplier LSB is set, then shift right.
    assign mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
    assign mul_next = {mul_sum, work[31:1]};

    // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
    // With a zero divisor every step "fits", leaving quotient all-ones and remainder |A|.
    assign div_shift = {work[63:32], work[31]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift[31:0] - opnd;
    assign div_next  = {(div_ge ? div_diff : div_shift[31:0]), work[30:0], div_ge};

    assign prod_fix = neg_if64(neg_q, work);

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: 32 RUN cycles then one FIN cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (count == 6'd31) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, result write-back and PAS moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 6'd0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= 32'd0;
            work     <= 64'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        count    <= 6'd0;
                        is_div   <= op_div;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (B == 32'd0);
                        opnd     <= op_div ? abs_b : abs_a;
                        work     <= {32'd0, (op_div ? abs_a : abs_b)};
                    end else if (start && (CtrlALUOp == OP_PAS)) begin
                        if (CtrlHiSel) hi <= A;
                        else           lo <= A;
                    end
                end
                RUN: begin
                    work  <= is_div ? div_next : mul_next;
                    count <= count + 6'd1;
                end
                FIN: begin
                    if (is_div) begin
                        hi <= neg_if32(neg_r, work[63:32]);
                        lo <= div_zero ? 32'hFFFF_FFFF : neg_if32(neg_q, work[31:0]);
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed table, hand-written
// corner sequences and randomized operations against an arithmetic model.
module tb_mips_cpu_muldiv;

    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_MULU = 5'd22;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_DIVU = 5'd23;
    localparam logic [4:0] OP_PAS  = 5'd19;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  CtrlALUOp;
    logic        CtrlHiSel;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    mips_cpu_muldiv dut (
        .clk(clk), .reset(reset), .start(start), .CtrlALUOp(CtrlALUOp),
        .CtrlHiSel(CtrlHiSel), .A(A), .B(B),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_MUL:  begin q = sa * sb; return q; end
            OP_MULU: begin u = {32'd0, a} * {32'd0, b}; return u; end
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a negedge; start is sampled at the following edge (edge 0).
    // Returns at the negedge of cycle 1.
    task automatic launch(input logic [4:0] op, input logic sel, input logic [31:0] a, input logic [31:0] b);
        CtrlALUOp = op; CtrlHiSel = sel; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    // Full operation with latency checks; returns at the negedge of cycle 34.
    task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        logic lat_ok;
        launch(op, 1'b0, a, b);
        lat_ok = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) lat_ok = 1'b0;
            @(negedge clk);
        end
        check({name, " busy1..33"}, {63'd0, lat_ok}, 64'd1);
        check({name, " done/busy@34"}, {62'd0, done, busy}, 64'd2);
        check({name, " hi"}, {32'd0, hi}, {32'd0, ehi});
        check({name, " lo"}, {32'd0, lo}, {32'd0, elo});
    endtask

    initial begin
        logic        quiet;
        logic [31:0] ra, rb;
        logic [4:0]  rop;
        logic [63:0] exp;
        logic [4:0]  ops[4];

        ops[0] = OP_MUL; ops[1] = OP_MULU; ops[2] = OP_DIV; ops[3] = OP_DIVU;

        vecs[0] = '{OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{OP_MUL,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
        vecs[4] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[6] = '{OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7] = '{OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[8] = '{OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[9] = '{OP_MULU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};

        reset = 1'b1; start = 1'b0; CtrlALUOp = 5'd0; CtrlHiSel = 1'b0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset state", {busy, done, hi, lo}, 66'd0);

        // PAS to HI then LO.
        launch(OP_PAS, 1'b1, 32'h1234_5678, 32'd0);
        check("pas hi", {busy, done, hi, lo}, {2'b00, 32'h1234_5678, 32'd0});
        launch(OP_PAS, 1'b0, 32'hCAFE_F00D, 32'd0);
        check("pas lo", {busy, done, hi, lo}, {2'b00, 32'h1234_5678, 32'hCAFE_F00D});

        // Unknown opcode is ignored.
        launch(5'd5, 1'b1, 32'hDEAD_BEEF, 32'd1);
        check("bad op ignored", {busy, done, hi, lo}, {2'b00, 32'h1234_5678, 32'hCAFE_F00D});

        // Second start at cycle 5 of a running op has no effect.
        launch(OP_MULU, 1'b0, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        CtrlALUOp = OP_MULU; A = 32'd9; B = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        quiet = 1'b1;
        for (int c = 6; c <= 33; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        check("intrude busy", {63'd0, quiet}, 64'd1);
        check("intrude result", {done, hi, lo}, {1'b1, 32'd0, 32'd12});
        @(negedge clk);
        check("done one cycle", {busy, done}, 2'b00);

        // Reset at cycle 10 of a running op.
        launch(OP_MULU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrun reset", {busy, done, hi, lo}, 66'd0);
        quiet = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        check("no done after reset", {63'd0, quiet}, 64'd1);
        do_op("mulu 3*5", OP_MULU, 32'd3, 32'd5, 32'd0, 32'd15);

        // Reset while in FIN (cycle 33) abandons the write-back.
        launch(OP_MULU, 1'b0, 32'd6, 32'd7);
        repeat (32) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("fin reset", {busy, done, hi, lo}, 66'd0);

        // Directed table, run back-to-back.
        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        @(negedge clk);
        check("idle after table", {busy, done}, 2'b00);

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            rop = ops[$urandom_range(0, 3)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = rb >> $urandom_range(1, 31);
                default: ;
            endcase
            exp = model(rop, ra, rb);
            do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, exp[63:32], exp[31:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; these are the clk and reset ports below.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous reset, active-high.
REQ-004 SHALL have port start, input, 1 bit: request valid this cycle.
REQ-005 SHALL have port CtrlALUOp, input, 5 bits: operation code; 2=MUL, 22=MULU, 3=DIV, 23=DIVU, 19=PAS (move to HI/LO).
REQ-006 SHALL have port CtrlHiSel, input, 1 bit: for PAS, 1 selects HI and 0 selects LO.
REQ-007 SHALL have port A, input, 32 bits: rs operand (dividend or multiplicand).
REQ-008 SHALL have port B, input, 32 bits: rt operand (divisor or multiplier).
REQ-009 SHALL have port busy, output, 1 bit: iterative operation in progress; the CPU stalls on it.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse, new HI/LO visible.
REQ-011 SHALL have port hi, output, 32 bits: HI register.
REQ-012 SHALL have port lo, output, 32 bits: LO register.

Function
REQ-013 SHALL implement states IDLE, RUN and FIN.
REQ-014 SHALL accept start only in IDLE; any start with busy=1 is ignored and has no effect.
REQ-015 SHALL, in IDLE on start with an op of 2, 3, 22 or 23, latch A, B and the op and go to RUN with iteration count 0.
REQ-016 SHALL, in IDLE on start with PAS, write A into HI if CtrlHiSel=1, else into LO, at that edge; busy stays 0 and no done pulse is produced.
REQ-017 SHALL ignore start with any other CtrlALUOp value: no state change.
REQ-018 SHALL, for signed ops (MUL, DIV), convert operands to magnitudes at latch time and record the result signs.
REQ-019 SHALL, in RUN, perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, for exactly 32 cycles.
REQ-020 SHALL use a 6-bit iteration counter and go to FIN on the 32nd RUN cycle.
REQ-021 SHALL, in FIN, apply sign correction and register the result into hi/lo, go to IDLE, and assert done for the next cycle.
REQ-022 SHALL meet this latency: start sampled at edge 0; busy=1 in cycles 1..33; done=1 and new hi/lo in cycle 34; busy=0 in cycle 34.
REQ-023 SHALL accept a new start in cycle 34, i.e. back-to-back operation.
REQ-024 SHALL produce for MULT/MULTU: {HI,LO} = 64-bit product, two's complement for MUL, unsigned for MULU.
REQ-025 SHALL produce for DIV/DIVU: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
REQ-026 SHALL, on divide by zero, keep the full latency and produce HI = A and LO = 0xFFFFFFFF for both DIV and DIVU.
REQ-027 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000 and HI=0x00000000 with no trap.
REQ-028 SHALL leave hi/lo unchanged in every cycle except a PAS write or the FIN edge.
REQ-029 SHALL keep done low in all cycles other than the single cycle after FIN.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, set state=IDLE, hi=0, lo=0, busy=0, done=0, and clear the counter and internal datapath registers.
REQ-031 SHALL give reset priority over start, including mid-RUN and in FIN: the operation is abandoned, no done pulse follows, and hi/lo=0.

Verification
REQ-032 SHALL pass: MULU, A=B=0xFFFFFFFF -> busy cycles 1..33, done at cycle 34, HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 SHALL pass: MUL, A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-034 SHALL pass: DIV, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU, A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
REQ-035 SHALL pass: PAS with CtrlHiSel=1 and A=0x12345678 -> hi=0x12345678 next cycle, lo unchanged, busy and done stay 0; a second MULU start at cycle 5 of a running op is ignored and the results match the first op only.
REQ-036 SHALL pass: MULU start, reset at cycle 10 -> cycle 11 shows busy=0 and hi=lo=0, and done never pulses; a subsequent MULU 3*5 gives LO=15 and HI=0 with 34-cycle latency.
